// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the CPU data port and data_ram.
// Stores retire into a DEPTH-entry circular FIFO and drain to RAM whenever the
// CPU leaves the RAM port idle. Loads bypass the buffer and go straight to RAM.
// Optional feature macro STORE_FWD_EN: when defined, load data is byte-merged
// with matching buffered stores; when undefined, a load while stores are
// buffered stalls until the buffer has drained.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ram_en_i,
  input  logic        cpu_write_en_i,
  input  logic        cpu_read_en_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_select_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_o,
  output logic        ram_en_o,
  output logic        ram_write_en_o,
  output logic        ram_read_en_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_select_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e            state_q, state_d;
  logic [29:0]       addr_q [DEPTH];
  logic [3:0]        sel_q  [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic        is_store, is_load, full, stall, enq, deq, rd;
  logic [31:0] load_data;

  // Decode the request and decide stall / enqueue / drain / load for this cycle.
  always_comb begin
    is_store = cpu_ram_en_i & cpu_write_en_i;
    is_load  = cpu_ram_en_i & cpu_read_en_i;
    full     = (count_q == CntW'(DEPTH));
    stall    = 1'b0;
    if (rst) begin
      if ((is_store | is_load) & full) stall = 1'b1;
`ifndef STORE_FWD_EN
      // Without forwarding a load must wait until every buffered store is in RAM.
      if (is_load & (state_q == StHold)) stall = 1'b1;
`endif
    end
    // The RAM port is free for a drain only when the CPU is idle or stalled.
    deq = rst & (state_q == StHold) & valid_q[head_q] & (stall | ~(is_store | is_load));
    enq = rst & is_store & ~stall;
    rd  = is_load & ~stall;
  end

  assign stall_o = stall;

  // FIFO pointer, count and state next-state logic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      tail_d          = tail_q + PtrW'(1);
      count_d         = count_q + CntW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (deq) begin
      head_d          = head_q + PtrW'(1);
      count_d         = count_q - CntW'(1);
      valid_d[head_q] = 1'b0;
    end
    state_d = (count_d == '0) ? StEmpty : StHold;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_addr_i[31:2];
      sel_q[tail_q]  <= cpu_select_i;
      data_q[tail_q] <= cpu_data_i;
    end
  end

`ifdef STORE_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Merge RAM data with matching entries oldest to youngest so the youngest lane wins.
  always_comb begin
    load_data = ram_data_i;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (rst && valid_q[fwd_idx] && (addr_q[fwd_idx] == cpu_addr_i[31:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (sel_q[fwd_idx][b]) load_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
        end
      end
    end
  end
`else
  assign load_data = ram_data_i;
`endif

  // RAM port mux: a load has priority, otherwise the head entry drains.
  always_comb begin
    ram_en_o       = 1'b0;
    ram_write_en_o = 1'b0;
    ram_read_en_o  = 1'b0;
    ram_addr_o     = '0;
    ram_select_o   = '0;
    ram_data_o     = '0;
    cpu_data_o     = '0;
    if (rd) begin
      ram_en_o      = 1'b1;
      ram_read_en_o = 1'b1;
      ram_addr_o    = cpu_addr_i;
      ram_select_o  = cpu_select_i;
      cpu_data_o    = load_data;
    end else if (deq) begin
      ram_en_o       = 1'b1;
      ram_write_en_o = 1'b1;
      ram_addr_o     = {addr_q[head_q], 2'b00};
      ram_select_o   = sel_q[head_q];
      ram_data_o     = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer with a behavioural RAM and a write scoreboard.
// Expectations for loads over buffered stores follow STORE_FWD_EN.
module tb_data_store_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ram_en_i, cpu_write_en_i, cpu_read_en_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_select_i;
  logic        stall_o, ram_en_o, ram_write_en_o, ram_read_en_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_select_o;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  data_store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_ram_en_i   (cpu_ram_en_i),
    .cpu_write_en_i (cpu_write_en_i),
    .cpu_read_en_i  (cpu_read_en_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_select_i   (cpu_select_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_data_o     (cpu_data_o),
    .stall_o        (stall_o),
    .ram_en_o       (ram_en_o),
    .ram_write_en_o (ram_write_en_o),
    .ram_read_en_o  (ram_read_en_o),
    .ram_addr_o     (ram_addr_o),
    .ram_select_o   (ram_select_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_data_i)
  );

  always #5 clk = ~clk;

  // Behavioural data_ram: combinational read, byte-lane write at the edge.
  assign ram_data_i = mem[ram_addr_o[11:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (ram_en_o && ram_write_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_select_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
    end
  end

  // Every RAM write must match the oldest outstanding accepted store.
  always @(negedge clk) begin
    if (rst && ram_en_o && ram_write_en_o) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %h data %h, expected no write",
               ram_addr_o, ram_data_o);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        assert ({ram_addr_o, ram_select_o, ram_data_o} === e) else begin
          errors++;
          $error("FAIL ram_write: observed %h/%h/%h expected %h/%h/%h",
                 ram_addr_o, ram_select_o, ram_data_o, e.addr, e.sel, e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic we, input logic re, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    cpu_ram_en_i   = en;
    cpu_write_en_i = we;
    cpu_read_en_i  = re;
    cpu_addr_i     = a;
    cpu_select_i   = s;
    cpu_data_i     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Accepted store: no stall, no RAM activity, and a write expected later.
  task automatic store_ok(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    set_in(1'b1, 1'b1, 1'b0, a, s, d);
    exp_q.push_back('{addr: a, sel: s, data: d});
    @(negedge clk);
    chk("store_stall", 32'(stall_o), 32'h0);
    chk("store_ram_en", 32'(ram_en_o), 32'h0);
    tick();
  endtask

  task automatic drain_cycle(input logic [31:0] a);
    idle();
    @(negedge clk);
    chk("drain_we", 32'(ram_write_en_o), 32'h1);
    chk("drain_addr", ram_addr_o, a);
    tick();
  endtask

  task automatic load_check(input logic [31:0] a, input int nstall, input logic [31:0] d);
    set_in(1'b1, 1'b0, 1'b1, a, 4'hF, 32'h0);
    for (int k = 0; k < nstall; k++) begin
      @(negedge clk);
      chk("load_stall_hi", 32'(stall_o), 32'h1);
      chk("load_stall_drain", 32'(ram_write_en_o), 32'h1);
      tick();
    end
    @(negedge clk);
    chk("load_stall_lo", 32'(stall_o), 32'h0);
    chk("load_read_en", 32'(ram_read_en_o), 32'h1);
    chk("load_write_en", 32'(ram_write_en_o), 32'h0);
    chk("load_addr", ram_addr_o, a);
    chk("load_data", cpu_data_o, d);
    tick();
  endtask

  initial begin
    idle();
    pre_en  = 1'b1;
    pre_idx = 10'd8;
    pre_val = 32'hAAAAAAAA;
    // Reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_ram_en", 32'(ram_en_o), 32'h0);
    chk("rst_ram_we", 32'(ram_write_en_o), 32'h0);
    chk("rst_ram_re", 32'(ram_read_en_o), 32'h0);
    chk("rst_ram_addr", ram_addr_o, 32'h0);
    chk("rst_ram_sel", 32'(ram_select_o), 32'h0);
    chk("rst_ram_data", ram_data_o, 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    tick();
    pre_en = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_count", 32'(dut.count_q), 32'h0);

    // Single store then one idle cycle drains it
    store_ok(32'h100, 4'hF, 32'h11223344);
    chk("t1_count1", 32'(dut.count_q), 32'h1);
    drain_cycle(32'h100);
    chk("t1_count0", 32'(dut.count_q), 32'h0);

    // Fill to DEPTH, then a 5th store stalls while the head drains
    for (int i = 0; i < 4; i++) store_ok(32'(4 * i), 4'hF, 32'hA0 + 32'(i));
    chk("t2_full", 32'(dut.count_q), 32'h4);
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'hA4);
    @(negedge clk);
    chk("t2_stall", 32'(stall_o), 32'h1);
    chk("t2_drain_we", 32'(ram_write_en_o), 32'h1);
    chk("t2_drain_addr", ram_addr_o, 32'h0);
    tick();
    chk("t2_count3", 32'(dut.count_q), 32'h3);
    store_ok(32'h10, 4'hF, 32'hA4);
    chk("t2_count4", 32'(dut.count_q), 32'h4);
    for (int i = 1; i <= 4; i++) drain_cycle(32'(4 * i));
    chk("t2_count0", 32'(dut.count_q), 32'h0);

    // Byte-lane merge over RAM word 0xAAAAAAAA
    store_ok(32'h20, 4'b0001, 32'h000000BB);
    store_ok(32'h20, 4'b0010, 32'h0000CC00);
`ifdef STORE_FWD_EN
    load_check(32'h20, 0, 32'hAAAACCBB);
    drain_cycle(32'h20);
    drain_cycle(32'h20);
`else
    load_check(32'h20, 2, 32'hAAAACCBB);
`endif
    chk("t3_count0", 32'(dut.count_q), 32'h0);

    // Two full-word stores to one address: the younger wins
    store_ok(32'h40, 4'hF, 32'h1);
    store_ok(32'h40, 4'hF, 32'h2);
`ifdef STORE_FWD_EN
    load_check(32'h40, 0, 32'h2);
    drain_cycle(32'h40);
    drain_cycle(32'h40);
`else
    load_check(32'h40, 2, 32'h2);
`endif
    chk("t4_count0", 32'(dut.count_q), 32'h0);

    // Load while full stalls and drains the head first
    for (int i = 0; i < 4; i++) store_ok(32'h300 + 32'(4 * i), 4'hF, 32'hDEAD0300 + 32'(4 * i));
`ifdef STORE_FWD_EN
    load_check(32'h300, 1, 32'hDEAD0300);
    for (int i = 1; i < 4; i++) drain_cycle(32'h300 + 32'(4 * i));
`else
    load_check(32'h300, 4, 32'hDEAD0300);
`endif
    chk("t5_count0", 32'(dut.count_q), 32'h0);

    // Reset with stores buffered discards them
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 4'hF, 32'h5A5A0000 + 32'(i));
      tick();
    end
    chk("t6_count3", 32'(dut.count_q), 32'h3);
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_stall", 32'(stall_o), 32'h0);
    chk("t6_rst_ram_en", 32'(ram_en_o), 32'h0);
    chk("t6_rst_cpu_data", cpu_data_o, 32'h0);
    tick();
    rst = 1'b1;
    chk("t6_count0", 32'(dut.count_q), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_write", 32'(ram_en_o), 32'h0);
      tick();
    end

    chk("pending_writes", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
